// File: rtl/led_sw_pkg.sv
// Shared constants and types for the LED/switch Avalon-MM controller.
package led_sw_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 2;
   localparam int unsigned LED_W    = 8;
   localparam int unsigned SW_W     = 4;
   localparam int unsigned PERIOD_W = 24;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_LED    = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_PERIOD = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

   localparam int unsigned CTRL_MODE_BIT   = 0;
   localparam int unsigned CTRL_PAT_LSB    = 1;
   localparam int unsigned CTRL_PAT_MSB    = 2;
   localparam int unsigned CTRL_IRQ_EN_BIT = 3;
   localparam int unsigned STAT_CHG_BIT    = 8;

   typedef enum logic [1:0] {
      PAT_COUNT  = 2'd0,
      PAT_SCAN   = 2'd1,
      PAT_MIRROR = 2'd2,
      PAT_BLINK  = 2'd3
   } pat_e;

   typedef enum logic {
      SW_OWN  = 1'b0,
      PAT_OWN = 1'b1
   } own_e;

   typedef struct packed {
      logic irq_en;
      pat_e pat;
      logic mode;
   } ctrl_t;

endpackage

// File: rtl/led_sw_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line for the LED/switch controller.
interface led_sw_ctrl_if;
   import led_sw_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              irq;

   modport master (output address, read, write, writedata, input readdata, irq);
   modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/led_sw_ctrl_sw_debounce.sv
// One switch bit: 2-FF synchronizer followed by a hold-time debounce counter.
module sw_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw_in,
   output logic sw_db,
   output logic chg_c
);
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             db_q, db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count while the synchronized bit disagrees; accept it on the terminal count.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      chg_c = 1'b0;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            chg_c = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         db_q    <= 1'b0;
      end else begin
         sync1_q <= sw_in;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   assign sw_db = db_q;
endmodule

// File: rtl/led_sw_ctrl.sv
// LED bank / slide switch controller: register file, LED ownership FSM,
// pattern engine and debounced switch-change interrupt.
module led_sw_ctrl
   import led_sw_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned PERIOD_RESET    = 12500000
) (
   input  logic              clk,
   input  logic              reset_n,
   led_sw_ctrl_if.slave      bus,
   input  logic [SW_W-1:0]   sw_in,
   output logic [LED_W-1:0]  leds
);
   own_e                state_q, state_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic [LED_W-1:0]    led_data_q, led_data_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d, period_last_c;
   logic [LED_W-1:0]    pat_q, pat_d, pat_init_c;
   logic [LED_W-1:0]    leds_q, leds_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                dir_q, dir_d;
   logic                chg_q, chg_d;
   logic                irq_q, irq_d;
   logic                ctrl_wr_q, ctrl_wr_d;
   logic                restart_c, tick_c;
   logic                wr_ctrl_c, wr_led_c, wr_period_c, wr_status_c;
   logic [SW_W-1:0]     sw_db, sw_chg_c;
   logic                unused_c;

   for (genvar i = 0; i < SW_W; i++) begin : g_db
      sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk     (clk),
         .reset_n (reset_n),
         .sw_in   (sw_in[i]),
         .sw_db   (sw_db[i]),
         .chg_c   (sw_chg_c[i])
      );
   end

   assign wr_ctrl_c   = bus.write && (bus.address == ADDR_CTRL);
   assign wr_led_c    = bus.write && (bus.address == ADDR_LED);
   assign wr_period_c = bus.write && (bus.address == ADDR_PERIOD);
   assign wr_status_c = bus.write && (bus.address == ADDR_STATUS);
   assign unused_c    = ^bus.writedata[DATA_W-1:PERIOD_W];

   // Register file, chg set-wins-over-clear, and registered read mux.
   always_comb begin
      ctrl_d     = ctrl_q;
      led_data_d = led_data_q;
      period_d   = period_q;
      chg_d      = chg_q;
      ctrl_wr_d  = wr_ctrl_c;
      rdata_d    = '0;
      if (wr_ctrl_c) begin
         ctrl_d.mode   = bus.writedata[CTRL_MODE_BIT];
         ctrl_d.pat    = pat_e'(bus.writedata[CTRL_PAT_MSB:CTRL_PAT_LSB]);
         ctrl_d.irq_en = bus.writedata[CTRL_IRQ_EN_BIT];
      end
      if (wr_led_c)    led_data_d = bus.writedata[LED_W-1:0];
      if (wr_period_c) period_d   = bus.writedata[PERIOD_W-1:0];
      if (wr_status_c && bus.writedata[STAT_CHG_BIT]) chg_d = 1'b0;
      if (|sw_chg_c)   chg_d = 1'b1;
      irq_d = chg_d & ctrl_d.irq_en;
      if (bus.read) begin
         case (bus.address)
            ADDR_CTRL:   rdata_d = DATA_W'(ctrl_q);
            ADDR_LED:    rdata_d = DATA_W'(led_data_q);
            ADDR_PERIOD: rdata_d = DATA_W'(period_q);
            default: begin
               rdata_d[SW_W-1:0]    = sw_db;
               rdata_d[STAT_CHG_BIT] = chg_q;
            end
         endcase
      end
   end

   // Ownership FSM plus step counter and pattern engine.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SW_OWN:  if (ctrl_q.mode)  state_d = PAT_OWN;
         PAT_OWN: if (!ctrl_q.mode) state_d = SW_OWN;
         default: state_d = SW_OWN;
      endcase

      // ctrl_wr_q delays the restart so it sees the newly written pattern select.
      restart_c = (state_d == PAT_OWN) && ((state_q == SW_OWN) || ctrl_wr_q);

      case (ctrl_q.pat)
         PAT_SCAN:   pat_init_c = LED_W'(1);
         PAT_MIRROR: pat_init_c = {sw_db, sw_db};
         default:    pat_init_c = '0;
      endcase

      period_last_c = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
      tick_c        = (state_q == PAT_OWN) && (cnt_q == period_last_c);

      cnt_d = cnt_q + PERIOD_W'(1);
      pat_d = pat_q;
      dir_d = dir_q;
      if ((state_q != PAT_OWN) || restart_c || wr_period_c || tick_c) cnt_d = '0;

      if (restart_c) begin
         pat_d = pat_init_c;
         dir_d = 1'b0;
      end else if (state_q == PAT_OWN) begin
         if (ctrl_q.pat == PAT_MIRROR) begin
            pat_d = {sw_db, sw_db};
         end else if (tick_c) begin
            case (ctrl_q.pat)
               PAT_COUNT: pat_d = pat_q + LED_W'(1);
               PAT_BLINK: pat_d = ~pat_q;
               default: begin
                  // dir_q: 0 = shifting left, 1 = shifting right; bounce at the ends.
                  if (!dir_q) begin
                     if (pat_q[LED_W-1]) begin
                        pat_d = pat_q >> 1;
                        dir_d = 1'b1;
                     end else begin
                        pat_d = pat_q << 1;
                     end
                  end else begin
                     if (pat_q[0]) begin
                        pat_d = pat_q << 1;
                        dir_d = 1'b0;
                     end else begin
                        pat_d = pat_q >> 1;
                     end
                  end
               end
            endcase
         end
      end

      leds_d = (state_d == PAT_OWN) ? (restart_c ? pat_init_c : pat_q) : led_data_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= SW_OWN;
         ctrl_q     <= '0;
         led_data_q <= '0;
         period_q   <= PERIOD_W'(PERIOD_RESET);
         cnt_q      <= '0;
         pat_q      <= '0;
         dir_q      <= 1'b0;
         chg_q      <= 1'b0;
         irq_q      <= 1'b0;
         ctrl_wr_q  <= 1'b0;
         leds_q     <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         led_data_q <= led_data_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         pat_q      <= pat_d;
         dir_q      <= dir_d;
         chg_q      <= chg_d;
         irq_q      <= irq_d;
         ctrl_wr_q  <= ctrl_wr_d;
         leds_q     <= leds_d;
         rdata_q    <= rdata_d;
      end
   end

   assign leds         = leds_q;
   assign bus.readdata = rdata_q;
   assign bus.irq      = irq_q;
endmodule

// File: doc/led_sw_ctrl.md
# led_sw_ctrl

Avalon-MM slave that owns the board LED bank and slide switches on the lightweight HPS-to-FPGA bus, replacing the plain LED/SW PIO pair. It arbitrates LED ownership between a software data register and a hardware pattern engine, debounces the four switches, and raises a level interrupt on a debounced switch change. It sits inside `soc_system` on `clk_clk`, and its conduits drive `LED[7:0]` and `SW[3:0]`.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: cycles a synchronized switch bit must hold a new value before it is accepted (1 ms at 50 MHz). Minimum 2.
- `PERIOD_RESET`, default 12500000: reset value of PERIOD, in clocks per pattern step.
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous active-low reset.
- `address`  in  2  word address.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data; fixed read latency of 1, no waitrequest.
- `irq`  out  1  level interrupt, `STATUS.chg & CTRL.irq_en`.
- `sw_in`  in  4  raw switches, asynchronous to `clk`.
- `leds`  out  8  LED drive, registered.

## Operation
- **Registers** (unused bits read 0):
  - 0 CTRL: bit0 `mode` (0 = software, 1 = pattern); bits[2:1] `pat` (0 COUNT, 1 SCAN, 2 MIRROR, 3 BLINK); bit3 `irq_en`. Reset value 0.
  - 1 LED_DATA: bits[7:0]. Reset value 0.
  - 2 PERIOD: bits[23:0]. Reset value `PERIOD_RESET`. A value of 0 is treated as 1.
  - 3 STATUS: bits[3:0] debounced switch value (read-only); bit8 `chg` (write 1 to clear). Writes to bits[3:0] are ignored.
- **Ownership FSM** with states SW_OWN and PAT_OWN.
  - SW_OWN: `leds` follows LED_DATA.
  - PAT_OWN: `leds` follows the pattern register.
  - Transitions follow `CTRL.mode`.
  - On every entry to PAT_OWN, and on any write to CTRL while in PAT_OWN, the step counter and the pattern register are reset to their initial values.
- **Step counter**: counts 0..max(PERIOD,1)-1 and emits a one-cycle `tick` on the terminal count. The counter runs only in PAT_OWN.
  - A PERIOD write restarts the counter at 0.
- **Patterns**, advanced on `tick`:
  - COUNT: 8-bit increment from 0x00. Wraps 0xFF→0x00.
  - SCAN: starts at 0x01 with direction left and shifts one bit per tick. At 0x80 the direction flips to right; at 0x01 it flips to left. The end values are shown for one tick only (0x40 follows 0x80).
  - BLINK: starts at 0x00 and inverts all bits each tick.
  - MIRROR: pattern = `{sw_db, sw_db}` every cycle; it does not wait for ticks.
- **Debounce**, per bit:
  - `sw_in` passes through a 2-FF synchronizer.
  - When the synchronized bit differs from `sw_db`, a counter increments. When the two are equal, the counter clears.
  - At `DEBOUNCE_CYCLES`-1 the counter clears, `sw_db` takes the new value, and `chg` is set.
  - Reset: `sw_db` = 0 and all counters = 0.
- **`chg` set/clear collision**: if a debounced change and a W1C of `chg` occur in the same cycle, the set wins.
- **Reads**: `readdata` is registered; it returns the addressed register when `read` is high and 0 otherwise.

## Timing
- Write accepted in cycle N → register value updates in cycle N+1 → `leds` reflects it in cycle N+2.
- Read in cycle N → `readdata` is valid in cycle N+1.
- `tick` occurs in cycle T → the pattern register updates in T+1 → `leds` updates in T+2.
- The first tick after entering PAT_OWN comes max(PERIOD,1) cycles after entry.
- While the step counter is running, the pattern register holds its initial value, so `leds` shows the initial value from the cycle after entry until the first tick. MIRROR is the exception: it updates every cycle.
- Switch latency: a change on `sw_in` appears in `STATUS` after 2 synchronizer cycles plus `DEBOUNCE_CYCLES` cycles. `irq` rises in the same cycle as `chg`.
- Reset asserted mid-operation:
  - All state returns to reset values immediately (asynchronously).
  - `leds`, `readdata` and `irq` go to 0.
  - Outputs stay at reset values until the first edge after `reset_n` rises.

## Structure
- Package `led_sw_pkg` holds:
  - register address constants (0..3);
  - CTRL and STATUS bit positions;
  - the pattern-select enum (COUNT/SCAN/MIRROR/BLINK);
  - the ownership-state enum.
- One sub-module, `sw_debounce`: a single bit with synchronizer and counter, parameterized by `DEBOUNCE_CYCLES`, instantiated 4 times.

## Test plan
- **Reset values**: reset, then read all registers → CTRL=0, LED_DATA=0, PERIOD=`PERIOD_RESET`, STATUS=0; `leds`=0, `irq`=0.
- **Software mode**: write LED_DATA=0xA5 in cycle N → `leds`=0xA5 in N+2; read back 0xA5 with latency 1.
- **COUNT**:
  - PERIOD=4, CTRL=0x1 → `leds` steps 0x00, 0x01, 0x02… every 4 cycles.
  - Preload via 255 ticks → wraps 0xFF→0x00.
  - Mid-run write of CTRL=0x0 → `leds`=LED_DATA two cycles later.
- **SCAN and BLINK**:
  - SCAN with PERIOD=1 → 0x01, 0x02 … 0x80, 0x40 … 0x01, 0x02.
  - BLINK → alternates 0x00 and 0xFF.
  - PERIOD=0 behaves the same as PERIOD=1.
- **Debounce**:
  - With `DEBOUNCE_CYCLES`=8: a glitch on `sw_in[2]` lasting 5 cycles leaves STATUS=0.
  - Holding `sw_in`=0x4 → STATUS=0x104 after 10 cycles; `irq`=1 if `irq_en` is set.
  - Writing 0x100 to STATUS clears `irq`.
  - A W1C in the same cycle as a new change leaves `chg`=1.
- **Reset mid-pattern**: assert `reset_n`=0 during COUNT at 0x37 → `leds`=0 at once; after release, mode=software and `leds`=0.
